// File: rtl/dda_ode_solver.sv
// dda_ode_solver: NCH-channel fixed-point DDA integrator (forward Euler) for the
// chain ODE y[k]' = y[k+1], y[NCH-1]' = +/-y[0]. Runs n_steps Euler steps per
// start/done handshake, dt = 2^-DT_SHIFT, values are signed Q(W-FRAC).FRAC.
//
// Build option: define DDA_SAT_EN to saturate overflowing channel adds instead
// of wrapping them. ovf is set sticky in both builds.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start           1-cycle run request, honoured in IDLE (wins over stop)
//   stop            abort request, honoured in RUN (no update, no done)
//   mode            0: y[NCH-1]' = +y[0], 1: y[NCH-1]' = -y[0]; latched on start
//   n_steps         Euler steps per run; latched on start
//   y_init          initial state, channel k at [k*W +: W]; loaded on start
//   busy            high while running
//   done            1-cycle pulse on normal completion
//   t               elapsed time, same Q format, wraps modulo 2^W
//   y               state vector, same packing as y_init
//   step_cnt        steps completed in the current/last run
//   ovf             sticky overflow flag, cleared on accepted start
module dda_ode_solver #(
    parameter int unsigned W        = 32,
    parameter int unsigned FRAC     = 16,
    parameter int unsigned NCH      = 2,
    parameter int unsigned DT_SHIFT = 9,
    parameter int unsigned CW       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CW-1:0]    n_steps,
    input  logic [NCH*W-1:0] y_init,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     t,
    output logic [NCH*W-1:0] y,
    output logic [CW-1:0]    step_cnt,
    output logic             ovf
);

    localparam logic [W-1:0] T_INC = W'(1) << (FRAC - DT_SHIFT);
    localparam logic [W-1:0] Y_MIN = {1'b1, {(W-1){1'b0}}};
`ifdef DDA_SAT_EN
    localparam logic [W-1:0] Y_MAX = {1'b0, {(W-1){1'b1}}};
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [NCH*W-1:0] y_q, y_d, y_step;
    logic [W-1:0]     t_q, t_d;
    logic [CW-1:0]    step_cnt_q, step_cnt_d, step_cnt_nxt;
    logic [CW-1:0]    n_q, n_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     y0, neg_y0;
    logic             neg_ovf;
    logic [NCH-1:0]   ch_ovf;

    // Feedback term for the last channel; negating the most-negative value wraps.
    assign y0      = y_q[W-1:0];
    assign neg_y0  = W'(0) - y0;
    assign neg_ovf = mode_q && (y0 == Y_MIN);

    // One Euler update per channel, all computed from the registered state.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [W-1:0] a, d, inc, sum;
        assign a = y_q[k*W +: W];
        if (k < NCH - 1) begin : g_chain
            assign d = y_q[(k+1)*W +: W];
        end else begin : g_fb
            assign d = mode_q ? neg_y0 : y0;
        end
        assign inc       = W'($signed(d) >>> DT_SHIFT);
        assign sum       = a + inc;
        assign ch_ovf[k] = (a[W-1] == inc[W-1]) && (sum[W-1] != a[W-1]);
`ifdef DDA_SAT_EN
        assign y_step[k*W +: W] = ch_ovf[k] ? (a[W-1] ? Y_MIN : Y_MAX) : sum;
`else
        assign y_step[k*W +: W] = sum;
`endif
    end

    assign step_cnt_nxt = step_cnt_q + CW'(1);

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        t_d        = t_q;
        step_cnt_d = step_cnt_q;
        n_d        = n_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    y_d        = y_init;
                    t_d        = '0;
                    step_cnt_d = '0;
                    ovf_d      = 1'b0;
                    n_d        = n_steps;
                    mode_d     = mode;
                    if (n_steps != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    y_d        = y_step;
                    t_d        = t_q + T_INC;
                    step_cnt_d = step_cnt_nxt;
                    ovf_d      = ovf_q | (|ch_ovf) | neg_ovf;
                    if (step_cnt_nxt == n_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            y_q        <= '0;
            t_q        <= '0;
            step_cnt_q <= '0;
            n_q        <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            t_q        <= t_d;
            step_cnt_q <= step_cnt_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign t        = t_q;
    assign y        = y_q;
    assign step_cnt = step_cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_dda_ode_solver.sv
// Bench for dda_ode_solver: one NCH=1 instance and one NCH=2 instance, each
// tracked by a step-level arithmetic model, plus directed literal checks.
`timescale 1ns/1ps
module tb_dda_ode_solver;

    localparam int unsigned DT   = 9;
    localparam longint      MAXV = 64'sd2147483647;
    localparam longint      MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic        st1, sp1, md1, st2, sp2, md2;
    logic [15:0] n1, n2;
    logic [31:0] yi1;
    logic [63:0] yi2;
    logic        busy1, done1, ovf1, busy2, done2, ovf2;
    logic [31:0] t1, t2, y1o;
    logic [63:0] y2o;
    logic [15:0] c1, c2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dda_ode_solver #(.W(32), .FRAC(16), .NCH(1), .DT_SHIFT(9), .CW(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(st1), .stop(sp1), .mode(md1),
        .n_steps(n1), .y_init(yi1), .busy(busy1), .done(done1), .t(t1),
        .y(y1o), .step_cnt(c1), .ovf(ovf1));

    dda_ode_solver #(.W(32), .FRAC(16), .NCH(2), .DT_SHIFT(9), .CW(16)) u_dut2 (
        .clk(clk), .reset(reset), .start(st2), .stop(sp2), .mode(md2),
        .n_steps(n2), .y_init(yi2), .busy(busy2), .done(done2), .t(t2),
        .y(y2o), .step_cnt(c2), .ovf(ovf2));

    // Model state per instance (0: NCH=1, 1: NCH=2); mrem = steps still to run.
    longint   my [2][2];
    bit [31:0] mt [2];
    int       mcnt [2];
    int       mrem [2];
    bit       mdone [2];
    bit       movf [2];
    bit       mmode [2];

    function automatic longint s32(input logic [31:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint wrap32(input longint v);
        logic [31:0] x;
        x = v[31:0];
        return longint'($signed(x));
    endfunction

    function automatic logic [31:0] lo32(input longint v);
        return v[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One Euler step with wide arithmetic: out-of-range results are overflows.
    task automatic model_step(input int i, input int nch);
        longint d [2];
        longint nx [2];
        longint s;
        for (int k = 0; k < nch; k++) begin
            if (k < nch - 1) d[k] = my[i][k+1];
            else begin
                d[k] = mmode[i] ? -my[i][0] : my[i][0];
                if (d[k] > MAXV) begin
                    d[k] = wrap32(d[k]);
                    movf[i] = 1'b1;
                end
            end
        end
        for (int k = 0; k < nch; k++) begin
            s = my[i][k] + (d[k] >>> DT);
            if (s > MAXV || s < MINV) begin
                movf[i] = 1'b1;
`ifdef DDA_SAT_EN
                s = (s > MAXV) ? MAXV : MINV;
`else
                s = wrap32(s);
`endif
            end
            nx[k] = s;
        end
        for (int k = 0; k < nch; k++) my[i][k] = nx[k];
        mt[i] = mt[i] + 32'h80;
        mcnt[i]++;
    endtask

    task automatic model_edge(input int i, input int nch, input bit st, input bit sp,
                              input bit md, input int n, input longint i0, input longint i1);
        mdone[i] = 1'b0;
        if (mrem[i] == 0) begin
            if (st) begin
                my[i][0] = i0;
                my[i][1] = i1;
                mt[i]    = 32'h0;
                mcnt[i]  = 0;
                movf[i]  = 1'b0;
                mmode[i] = md;
                if (n == 0) mdone[i] = 1'b1;
                else        mrem[i]  = n;
            end
        end else if (sp) begin
            mrem[i] = 0;
        end else begin
            model_step(i, nch);
            mrem[i]--;
            if (mrem[i] == 0) mdone[i] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                my[i][0] = 0; my[i][1] = 0; mt[i] = 32'h0; mcnt[i] = 0;
                mrem[i] = 0; mdone[i] = 1'b0; movf[i] = 1'b0; mmode[i] = 1'b0;
            end
        end else begin
            model_edge(0, 1, st1, sp1, md1, int'(n1), s32(yi1), 0);
            model_edge(1, 2, st2, sp2, md2, int'(n2), s32(yi2[31:0]), s32(yi2[63:32]));
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("busy1", 64'(busy1), 64'(mrem[0] != 0));
        chk("done1", 64'(done1), 64'(mdone[0]));
        chk("ovf1",  64'(ovf1),  64'(movf[0]));
        chk("t1",    64'(t1),    64'(mt[0]));
        chk("cnt1",  64'(c1),    64'(mcnt[0][15:0]));
        chk("y1",    64'(y1o),   64'(lo32(my[0][0])));
        chk("busy2", 64'(busy2), 64'(mrem[1] != 0));
        chk("done2", 64'(done2), 64'(mdone[1]));
        chk("ovf2",  64'(ovf2),  64'(movf[1]));
        chk("t2",    64'(t2),    64'(mt[1]));
        chk("cnt2",  64'(c2),    64'(mcnt[1][15:0]));
        chk("y2_0",  64'(y2o[31:0]),  64'(lo32(my[1][0])));
        chk("y2_1",  64'(y2o[63:32]), 64'(lo32(my[1][1])));
    end

    task automatic pulse1();
        @(negedge clk) st1 = 1'b1;
        @(negedge clk) st1 = 1'b0;
    endtask

    task automatic pulse2();
        @(negedge clk) st2 = 1'b1;
        @(negedge clk) st2 = 1'b0;
    endtask

    task automatic wait_done1(input int lim, output int bc);
        int n;
        bc = 0;
        n  = 0;
        while (!done1 && n < lim) begin
            if (busy1) bc++;
            @(negedge clk);
            n++;
        end
        chk("done1_reached", 64'(done1), 64'(1));
    endtask

    task automatic wait_done2(input int lim, output int bc);
        int n;
        bc = 0;
        n  = 0;
        while (!done2 && n < lim) begin
            if (busy2) bc++;
            @(negedge clk);
            n++;
        end
        chk("done2_reached", 64'(done2), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int bc;
        int n;
        int yv;
        reset = 1'b1;
        st1 = 1'b0; sp1 = 1'b0; md1 = 1'b0; n1 = '0; yi1 = '0;
        st2 = 1'b0; sp2 = 1'b0; md2 = 1'b0; n2 = '0; yi2 = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy1", 64'(busy1), 64'(0));
        chk("rst_y1",    64'(y1o),   64'(0));
        chk("rst_t1",    64'(t1),    64'(0));
        chk("rst_ovf2",  64'(ovf2),  64'(0));
        chk("rst_y2",    y2o,        64'(0));
        reset = 1'b1;

        // Exponential growth: e ~ 2.718 after t = 1.0.
        md1 = 1'b0; yi1 = 32'h0001_0000; n1 = 16'd512;
        pulse1();
        wait_done1(700, bc);
        chk("t1_busy_cycles", 64'(bc), 64'(512));
        chk("t1_time",        64'(t1), 64'(32'h0001_0000));
        chk("t1_yrange",      64'(y1o >= 32'h0002_B333 && y1o <= 32'h0002_B851), 64'(1));
        chk("t1_ovf",         64'(ovf1), 64'(0));

        // Oscillator: a single step, then a full period.
        md2 = 1'b1; yi2 = {32'h0001_0000, 32'h0}; n2 = 16'd1;
        pulse2();
        wait_done2(10, bc);
        chk("t2_step_y0", 64'(y2o[31:0]),  64'(32'h0000_0080));
        chk("t2_step_y1", 64'(y2o[63:32]), 64'(32'h0001_0000));
        n2 = 16'd3217;
        pulse2();
        wait_done2(4000, bc);
        chk("t2_period_y1", 64'(y2o[63:32] >= 32'd64880 && y2o[63:32] <= 32'd66191), 64'(1));
        yv = $signed(y2o[31:0]);
        chk("t2_period_y0", 64'(yv > -2048 && yv < 2048), 64'(1));

        // Zero-step run: immediate done, state loaded.
        yi1 = 32'h1234_5678; n1 = 16'd0;
        pulse1();
        chk("t3_busy", 64'(busy1), 64'(0));
        chk("t3_done", 64'(done1), 64'(1));
        chk("t3_y",    64'(y1o),   64'(32'h1234_5678));
        chk("t3_t",    64'(t1),    64'(0));
        chk("t3_cnt",  64'(c1),    64'(0));
        @(negedge clk);
        chk("t3_done_off", 64'(done1), 64'(0));

        // Overflow on the first step.
        yi1 = 32'h7FFF_0000; n1 = 16'd2;
        pulse1();
        @(negedge clk);
`ifdef DDA_SAT_EN
        chk("t4_step1_y", 64'(y1o), 64'(32'h7FFF_FFFF));
`else
        chk("t4_step1_y", 64'(y1o), 64'(32'h803E_FF80));
`endif
        chk("t4_step1_ovf", 64'(ovf1), 64'(1));
        wait_done1(10, bc);
        chk("t4_ovf", 64'(ovf1), 64'(1));
`ifdef DDA_SAT_EN
        chk("t4_sat_y", 64'(y1o), 64'(32'h7FFF_FFFF));
`endif

        // Stop at step 40 with a stray start mid-run.
        yi1 = 32'h7FFF_0000; n1 = 16'd100;
        pulse1();
        n = 0;
        while (c1 != 16'd40 && n < 200) begin
            st1 = (n == 10);
            @(negedge clk);
            n++;
        end
        st1 = 1'b0;
        chk("t5_reach40", 64'(c1), 64'(40));
        sp1 = 1'b1;
        @(negedge clk) sp1 = 1'b0;
        chk("t5_busy", 64'(busy1), 64'(0));
        chk("t5_cnt",  64'(c1),    64'(40));
        chk("t5_done", 64'(done1), 64'(0));
        chk("t5_ovf_kept", 64'(ovf1), 64'(1));
        sp1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_idle_stop", 64'(c1), 64'(40));
        // start and stop together in IDLE: start wins and clears ovf.
        yi1 = 32'h0002_0000; n1 = 16'd3; st1 = 1'b1;
        @(negedge clk) begin st1 = 1'b0; sp1 = 1'b0; end
        chk("t5_reload_ovf", 64'(ovf1),  64'(0));
        chk("t5_reload_y",   64'(y1o),   64'(32'h0002_0000));
        chk("t5_reload_busy", 64'(busy1), 64'(1));
        wait_done1(10, bc);
        chk("t5_reload_cnt", 64'(c1), 64'(3));

        // Asynchronous reset mid-run, then a clean run.
        md2 = 1'b1; yi2 = {32'h0001_0000, 32'h0}; n2 = 16'd1000;
        pulse2();
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_busy", 64'(busy2), 64'(0));
        chk("t6_y",    y2o,        64'(0));
        chk("t6_t",    64'(t2),    64'(0));
        chk("t6_cnt",  64'(c2),    64'(0));
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        n2 = 16'd10;
        pulse2();
        wait_done2(50, bc);
        chk("t6_run_cnt",  64'(c2), 64'(10));
        chk("t6_run_busy", 64'(bc), 64'(10));
        chk("t6_run_t",    64'(t2), 64'(32'h0000_0500));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
